rx_frame_fifo: RTL

Receive-side buffer downstream of the UART RX frame controller. Captures each validated byte presented on the deserializer's parallel output when the controller flags `Data_Valid`, and stores it in a small FIFO. Presents bytes to the consumer through a valid/ready handshake. Tracks fill level, almost-full, overflow and dropped-byte count so software-facing logic can detect lost frames.

---
 rtl/rx_frame_fifo.sv | 84 ++++++++
 1 files changed

// File: rtl/rx_frame_fifo.sv
// Receive-side byte FIFO behind the UART RX frame controller: edge-detected capture,
// first-word fall-through valid/ready read port, fill level, sticky overflow and drop counter.
module rx_frame_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DATA_WIDTH-1:0]  P_Data,
    input  logic                   Data_Valid,
    input  logic                   Clear,
    input  logic                   Rd_Ready,
    output logic [DATA_WIDTH-1:0]  Rd_Data,
    output logic                   Rd_Valid,
    output logic [$clog2(DEPTH):0] Level,
    output logic                   Almost_Full,
    output logic                   Overflow,
    output logic [7:0]             Drop_Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_LEVEL = PW'(AF_THRESH);

    logic                  dv_q;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  overflow_q;
    logic [7:0]            drop_q;

    logic wr_req;
    logic rd_fire;
    logic empty;
    logic full;
    logic wr_accept;
    logic wr_drop;

    // NOTE: every signal gets its value on every path through this block, so no latches.
    always_comb begin
        wr_req    = Data_Valid & ~dv_q;
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        rd_fire   = ~empty & Rd_Ready;
        wr_accept = wr_req & (~full | rd_fire);
        wr_drop   = wr_req & full & ~rd_fire;
    end

    // Tracks the strobe even during reset/clear so a strobe still high afterwards is not re-captured.
    always_ff @(posedge CLK) begin
        dv_q <= Data_Valid;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (RST || Clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + PW'(1);
            if (rd_fire)   rd_ptr <= rd_ptr + PW'(1);
            if (wr_drop) begin
                overflow_q <= 1'b1;
                if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            end
        end
    end

    // NOTE: storage is not reset; Rd_Data is only meaningful while Rd_Valid is high.
    always_ff @(posedge CLK) begin
        if (!RST && !Clear && wr_accept) mem[wr_ptr[AW-1:0]] <= P_Data;
    end

    assign Rd_Data     = mem[rd_ptr[AW-1:0]];
    assign Rd_Valid    = ~empty;
    assign Level       = wr_ptr - rd_ptr;
    assign Almost_Full = (Level >= AF_LEVEL);
    assign Overflow    = overflow_q;
    assign Drop_Count  = drop_q;

endmodule
